// File: rtl/fetch_unit.sv
// Instruction fetch: PC register drives imem, words queue in a DEPTH-entry FIFO toward decode.
// Latency 1 cycle fetch->instr_valid; fetch stalls while the FIFO is full and not draining.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic [31:0] fetch_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   fc_q, fc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];

    logic deq;
    logic enq;

    assign instr_valid = (count_q != '0);
    assign deq         = instr_valid & instr_ready;
    // A dequeue in the same cycle frees the slot, so a full FIFO keeps streaming.
    assign enq         = !redirect_valid & ((count_q < FULL_CNT) | deq);

    always_comb begin
        pc_d     = pc_q;
        fc_d     = fc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc & ~32'h3;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (enq) begin
                pc_d     = pc_q + 32'd4;
                fc_d     = fc_q + 32'd1;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            fc_q     <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            fc_q     <= fc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            pc_mem_q[wr_ptr_q]   <= pc_q;
            data_mem_q[wr_ptr_q] <= imem_data;
        end
    end

    assign imem_addr   = pc_q;
    assign fetch_count = fc_q;
    assign instr_data  = instr_valid ? data_mem_q[rd_ptr_q] : 32'h0;
    assign instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default instance plus one with RESET_PC near the top of memory.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr, imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_data, instr_pc, fetch_count;

    logic [31:0] imem_addr_w, imem_data_w;
    logic        instr_valid_w, instr_ready_w;
    logic [31:0] instr_data_w, instr_pc_w, fetch_count_w;

    int n_checks;
    int n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0:   mem_word = 32'h0031_00B3;
            32'h4:   mem_word = 32'h0030_8233;
            32'h8:   mem_word = 32'h4012_02B3;
            default: mem_word = addr ^ 32'hDEAD_0000;
        endcase
    endfunction

    assign imem_data   = mem_word(imem_addr);
    assign imem_data_w = mem_word(imem_addr_w);

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc),
        .fetch_count(fetch_count)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr_w), .imem_data(imem_data_w),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .instr_valid(instr_valid_w), .instr_ready(instr_ready_w),
        .instr_data(instr_data_w), .instr_pc(instr_pc_w),
        .fetch_count(fetch_count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        instr_ready    = 1'b0;
        instr_ready_w  = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
        n_checks++;
        if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 00000000", imem_addr); end
        n_checks++;
        if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_fcount: got %0d want 0", fetch_count); end
        n_checks++;
        if (instr_data !== 32'h0 || instr_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_head_zero: got data %h pc %h want 0 0", instr_data, instr_pc);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_dat [3];
        exp_pc[0] = 32'h0; exp_dat[0] = 32'h0031_00B3;
        exp_pc[1] = 32'h4; exp_dat[1] = 32'h0030_8233;
        exp_pc[2] = 32'h8; exp_dat[2] = 32'h4012_02B3;
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i] || instr_data !== exp_dat[i]) begin
                n_fail++;
                $display("FAIL stream[%0d]: got v=%0b pc=%h d=%h want v=1 pc=%h d=%h",
                         i, instr_valid, instr_pc, instr_data, exp_pc[i], exp_dat[i]);
            end
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_stall_and_full_throughput();
        do_reset();
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (instr_valid !== 1'b1 || imem_addr !== 32'h8 || fetch_count !== 32'd2 || instr_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL stall_hold: got v=%0b addr=%h fc=%0d pc=%h want v=1 addr=00000008 fc=2 pc=00000000",
                     instr_valid, imem_addr, fetch_count, instr_pc);
        end
        instr_ready = 1'b1;
        // Head before each edge is delivered at that edge; FIFO stays full while refilling.
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i) || instr_data !== mem_word(32'(4 * i))) begin
                n_fail++;
                $display("FAIL drain[%0d]: got v=%0b pc=%h d=%h want v=1 pc=%h d=%h",
                         i, instr_valid, instr_pc, instr_data, 32'(4 * i), mem_word(32'(4 * i)));
            end
            step();
            n_checks++;
            if (fetch_count !== 32'(3 + i) || imem_addr !== 32'(4 * (3 + i))) begin
                n_fail++;
                $display("FAIL full_tput[%0d]: got fc=%0d addr=%h want fc=%0d addr=%h",
                         i, fetch_count, imem_addr, 3 + i, 32'(4 * (3 + i)));
            end
        end
        instr_ready = 1'b0;
    endtask

    task automatic setup_holding_4_8();
        do_reset();
        step();
        step();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect();
        setup_holding_4_8();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0006;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h4 || fetch_count !== 32'd3) begin
            n_fail++;
            $display("FAIL redirect_bubble: got v=%0b addr=%h fc=%0d want v=0 addr=00000004 fc=3",
                     instr_valid, imem_addr, fetch_count);
        end
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr_data !== 32'h0030_8233) begin
            n_fail++;
            $display("FAIL redirect_first: got v=%0b pc=%h d=%h want v=1 pc=00000004 d=00308233",
                     instr_valid, instr_pc, instr_data);
        end
    endtask

    task automatic test_redirect_with_deq();
        setup_holding_4_8();
        n_checks++;
        if (instr_pc !== 32'h4) begin n_fail++; $display("FAIL rdeq_head: got pc=%h want 00000004", instr_pc); end
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0010;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || fetch_count !== 32'd3 || imem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL rdeq_flush: got v=%0b fc=%0d addr=%h want v=0 fc=3 addr=00000010",
                     instr_valid, fetch_count, imem_addr);
        end
        step();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr_data !== 32'hDEAD_0010) begin
            n_fail++;
            $display("FAIL rdeq_next: got v=%0b pc=%h d=%h want v=1 pc=00000010 d=dead0010",
                     instr_valid, instr_pc, instr_data);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        do_reset();
        n_checks++;
        if (imem_addr_w !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_reset_pc: got %h want fffffff8", imem_addr_w); end
        instr_ready_w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (instr_valid_w !== 1'b1 || instr_pc_w !== exp_pc[i] || instr_data_w !== mem_word(exp_pc[i])) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got v=%0b pc=%h d=%h want v=1 pc=%h d=%h",
                         i, instr_valid_w, instr_pc_w, instr_data_w, exp_pc[i], mem_word(exp_pc[i]));
            end
        end
        instr_ready_w = 1'b0;
    endtask

    task automatic test_reset_when_full();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (instr_valid !== 1'b1 || fetch_count !== 32'd2) begin
            n_fail++; $display("FAIL full_before_rst: got v=%0b fc=%0d want v=1 fc=2", instr_valid, fetch_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h0 || fetch_count !== 32'h0 || imem_addr_w !== 32'hFFFF_FFF8) begin
            n_fail++;
            $display("FAIL rst_full: got v=%0b addr=%h fc=%0d addr_w=%h want v=0 addr=00000000 fc=0 addr_w=fffffff8",
                     instr_valid, imem_addr, fetch_count, imem_addr_w);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_stream();
        test_stall_and_full_throughput();
        test_redirect();
        test_redirect_with_deq();
        test_pc_wrap();
        test_reset_when_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
